// File: rtl/dac_seq_pkg.sv
// Shared types, register map and helpers for the ramp-DAC sequencer.
// Build option DAC_SEQ_SHADOW_EN is consumed by dac_seq_regfile.
package dac_seq_pkg;

    localparam int MAX_STATES = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RISE,
        S_HOLD_HI,
        S_FALL,
        S_HOLD_LO,
        S_DONE
    } state_t;

    localparam logic [4:0] ADDR_UP0         = 5'd0;
    localparam logic [4:0] ADDR_DOWN0       = 5'd10;
    localparam logic [4:0] ADDR_UP_STATES   = 5'd20;
    localparam logic [4:0] ADDR_DOWN_STATES = 5'd21;
    localparam logic [4:0] ADDR_IDLE_LVL    = 5'd22;
    localparam logic [4:0] ADDR_HOLD_HI     = 5'd23;
    localparam logic [4:0] ADDR_HOLD_LO     = 5'd24;
    localparam logic [4:0] ADDR_REPEAT      = 5'd25;

    typedef struct packed {
        logic [8*MAX_STATES-1:0] up;
        logic [8*MAX_STATES-1:0] down;
        logic [7:0]              up_states;
        logic [7:0]              down_states;
        logic [7:0]              idle_lvl;
        logic [7:0]              hold_hi;
        logic [7:0]              hold_lo;
        logic [7:0]              repeat_n;
    } regs_t;

    localparam regs_t REGS_RESET = '{
        up:          '0,
        down:        '0,
        up_states:   8'd1,
        down_states: 8'd1,
        idle_lvl:    8'd0,
        hold_hi:     8'd0,
        hold_lo:     8'd0,
        repeat_n:    8'd1
    };

    // State counts must stay within 1..max_v so a ramp phase is never empty.
    function automatic logic [7:0] clamp_states(input logic [7:0] v, input int unsigned max_v);
        if (v == 8'd0) begin
            return 8'd1;
        end else if (32'(v) > max_v) begin
            return 8'(max_v);
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/dac_seq_regfile.sv
// Byte-addressed configuration registers for the DAC sequencer.
// With DAC_SEQ_SHADOW_EN, writes land in a shadow copy promoted on start or idle writes.
module dac_seq_regfile
    import dac_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       busy,
    input  logic       load,
    output regs_t      regs,
    output logic       wr_err
);

    regs_t live_q, live_d;
    logic  wr_err_q, wr_err_d;
    logic  addr_ok;

    function automatic regs_t apply_write(input regs_t r, input logic [4:0] a, input logic [7:0] d);
        regs_t n;
        n = r;
        for (int k = 0; k < MAX_STATES; k++) begin
            if (a == 5'(32'(ADDR_UP0) + k))   n.up[8*k +: 8]   = d;
            if (a == 5'(32'(ADDR_DOWN0) + k)) n.down[8*k +: 8] = d;
        end
        case (a)
            ADDR_UP_STATES:   n.up_states   = clamp_states(d, MAX_STATES);
            ADDR_DOWN_STATES: n.down_states = clamp_states(d, MAX_STATES);
            ADDR_IDLE_LVL:    n.idle_lvl    = d;
            ADDR_HOLD_HI:     n.hold_hi     = d;
            ADDR_HOLD_LO:     n.hold_lo     = d;
            ADDR_REPEAT:      n.repeat_n    = (d == 8'd0) ? 8'd1 : d;
            default:          ;
        endcase
        return n;
    endfunction

    assign addr_ok = (wr_addr <= ADDR_REPEAT);

`ifdef DAC_SEQ_SHADOW_EN
    regs_t shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en && addr_ok) begin
            shadow_d = apply_write(shadow_q, wr_addr, wr_data);
        end
        // The running sequence only ever sees live; idle writes promote immediately.
        live_d = live_q;
        if (load || (wr_en && addr_ok && !busy)) begin
            live_d = shadow_d;
        end
        wr_err_d = wr_en && !addr_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= REGS_RESET;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    logic unused_load;
    assign unused_load = load;

    always_comb begin
        live_d = live_q;
        if (wr_en && addr_ok && !busy) begin
            live_d = apply_write(live_q, wr_addr, wr_data);
        end
        wr_err_d = wr_en && (!addr_ok || busy);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= REGS_RESET;
            wr_err_q <= 1'b0;
        end else begin
            live_q   <= live_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign regs   = live_q;
    assign wr_err = wr_err_q;

endmodule

// File: rtl/dac_sequencer.sv
// Ramp-DAC sequencer: rise/hold/fall/hold periods repeated a programmed number of times.
// Optional build macro DAC_SEQ_SHADOW_EN selects shadowed configuration registers.
module dac_sequencer
    import dac_seq_pkg::*;
#(
    parameter int MAX_STATES = dac_seq_pkg::MAX_STATES,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [4:0]              wr_addr,
    input  logic [7:0]              wr_data,
    output logic                    wr_err,
    input  logic                    start,
    input  logic                    abort,
    output logic                    dac_en,
    output logic                    dac_set,
    output logic [8*MAX_STATES-1:0] up,
    output logic [8*MAX_STATES-1:0] down,
    output logic [7:0]              up_states,
    output logic [7:0]              down_states,
    output logic [7:0]              idle_lvl,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        period_cnt
);

    regs_t regs;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              dac_en_q, dac_en_d;
    logic              dac_set_q, dac_set_d;
    logic              done_q, done_d;

    logic              start_ok;
    logic              period_end;
    logic [CNT_W-1:0]  period_inc;
    logic [CNT_W-1:0]  up_len, down_len, hi_len, lo_len, rep_len;

    assign busy     = (state_q != S_IDLE);
    assign start_ok = (state_q == S_IDLE) && start && !abort;

    dac_seq_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .load    (start_ok),
        .regs    (regs),
        .wr_err  (wr_err)
    );

    assign up_len     = CNT_W'(regs.up_states);
    assign down_len   = CNT_W'(regs.down_states);
    assign hi_len     = CNT_W'(regs.hold_hi);
    assign lo_len     = CNT_W'(regs.hold_lo);
    assign rep_len    = CNT_W'(regs.repeat_n);
    assign period_inc = period_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        period_d   = period_q;
        period_end = 1'b0;

        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_d  = S_RISE;
                        cyc_d    = '0;
                        period_d = '0;
                    end
                end
                S_RISE: begin
                    if (cyc_q == up_len - 1'b1) begin
                        cyc_d   = '0;
                        state_d = (hi_len == '0) ? S_FALL : S_HOLD_HI;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                S_HOLD_HI: begin
                    if (cyc_q == hi_len - 1'b1) begin
                        cyc_d   = '0;
                        state_d = S_FALL;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                S_FALL: begin
                    if (cyc_q == down_len - 1'b1) begin
                        cyc_d = '0;
                        if (lo_len == '0) begin
                            period_end = 1'b1;
                        end else begin
                            state_d = S_HOLD_LO;
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                S_HOLD_LO: begin
                    if (cyc_q == lo_len - 1'b1) begin
                        cyc_d      = '0;
                        period_end = 1'b1;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (period_end) begin
                period_d = period_inc;
                state_d  = (period_inc == rep_len) ? S_DONE : S_RISE;
            end
        end

        // Outputs are decoded from the next state so they register alongside it.
        dac_en_d  = (state_d == S_RISE) || (state_d == S_HOLD_HI) ||
                    (state_d == S_FALL) || (state_d == S_HOLD_LO);
        dac_set_d = (state_d == S_RISE) || (state_d == S_HOLD_HI);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            period_q  <= '0;
            dac_en_q  <= 1'b0;
            dac_set_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            period_q  <= period_d;
            dac_en_q  <= dac_en_d;
            dac_set_q <= dac_set_d;
            done_q    <= done_d;
        end
    end

    assign dac_en      = dac_en_q;
    assign dac_set     = dac_set_q;
    assign done        = done_q;
    assign period_cnt  = period_q;
    assign up          = regs.up;
    assign down        = regs.down;
    assign up_states   = regs.up_states;
    assign down_states = regs.down_states;
    assign idle_lvl    = regs.idle_lvl;

endmodule

// File: doc/dac_sequencer.md
# dac_sequencer

Controller for the 8-bit ramp DAC. Holds the DAC's up/down ramp tables and state counts in a byte-addressed register file, then sequences the DAC's `en`/`set` inputs through programmable rise/hold/fall/hold periods, repeated a programmed number of times. Sits between the host/config logic and the DAC. All DAC configuration and timing comes from this block.

## Interface
Parameters:
- `MAX_STATES`, 10: table depth per ramp direction; also the clamp limit for the state counts.
- `CNT_W`, 8: width of the hold and repeat counters.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  register write strobe, one write per cycle.
- `wr_addr`  in  5  register address.
- `wr_data`  in  8  write data.
- `wr_err`  out  1  1-cycle pulse for a rejected write.
- `start`  in  1  level sampled each cycle; a start is accepted only in S_IDLE.
- `abort`  in  1  stops any active sequence.
- `dac_en`  out  1  drives DAC `en`.
- `dac_set`  out  1  drives DAC `set`.
- `up`  out  80  up table; entry k is at bits [8k+7:8k].
- `down`  out  80  down table, same packing.
- `up_states`  out  8  up-ramp state count, always 1..10.
- `down_states`  out  8  down-ramp state count, always 1..10.
- `idle_lvl`  out  8  DAC IDLE level.
- `busy`  out  1  high in every state except S_IDLE.
- `done`  out  1  1-cycle pulse when a sequence completes normally.
- `period_cnt`  out  8  number of completed periods in the current run.

## Operation
Register map:
- 0–9: up[0..9].
- 10–19: down[0..9].
- 20: up_states. Writes are clamped: 0→1, >10→10.
- 21: down_states, clamped the same way.
- 22: idle_lvl.
- 23: hold_hi.
- 24: hold_lo.
- 25: repeat. 0 is treated as 1.
- 26–31: reserved. A write pulses `wr_err` and has no effect.

FSM states: S_IDLE, S_RISE, S_HOLD_HI, S_FALL, S_HOLD_LO, S_DONE.
- S_IDLE: `dac_en`=0, `dac_set`=0. If `start`=1 and `abort`=0, load the counters and go to S_RISE.
- S_RISE: `dac_en`=1, `dac_set`=1, for up_states cycles. Then go to S_HOLD_HI, or to S_FALL if hold_hi=0.
- S_HOLD_HI: `dac_en`=1, `dac_set`=1, for hold_hi cycles, then S_FALL.
- S_FALL: `dac_en`=1, `dac_set`=0, for down_states cycles. Then go to S_HOLD_LO, or directly to the end-of-period decision if hold_lo=0.
- S_HOLD_LO: `dac_en`=1, `dac_set`=0, for hold_lo cycles.
- End of period: increment `period_cnt`. If `period_cnt` equals repeat, go to S_DONE; otherwise go to S_RISE.
- S_DONE: `dac_en`=0, `done`=1 for one cycle, then S_IDLE.

Rules:
- Period length is up_states + hold_hi + down_states + hold_lo cycles.
- `abort` takes priority over every transition. From any non-idle state the next state is S_IDLE, with no `done` pulse. `period_cnt` holds its value until the next start.
- A start loads all counters and clears `period_cnt`.
- `start` is ignored while `busy`=1.

## Timing
- Reset values:
  - All table bytes, idle_lvl, hold_hi, hold_lo: 0.
  - up_states, down_states, repeat: 1.
  - FSM in S_IDLE; all other outputs 0.
- Register writes are visible on the outputs the cycle after `wr_en`. `wr_err` is registered and pulses in that same cycle.
- `start` accepted at edge N: `dac_en`=`dac_set`=1 from N+1.
- Total busy time is repeat × period + 1 cycles, the extra cycle being S_DONE.
- All FSM outputs are registered; there is no combinational path from `start` or `abort` to `dac_en`/`dac_set`.
- A simultaneous `start` and `abort` in S_IDLE stays in S_IDLE.
- A simultaneous write and `start`: the write applies first. The run uses the newly written value.

## Configuration
Macro `DAC_SEQ_SHADOW_EN`.
- Defined:
  - Writes always land in a shadow register file.
  - Shadow contents are copied to the live outputs on an accepted start, and in S_IDLE the cycle after each write.
  - A write during `busy` therefore never disturbs the running sequence; it takes effect at the next start.
- Undefined:
  - There is a single register file.
  - Any write while `busy`=1 is rejected and pulses `wr_err`.

## Structure
- Package `dac_seq_pkg` holds:
  - the FSM state enum;
  - address constants ADDR_UP0 through ADDR_REPEAT;
  - `MAX_STATES`;
  - the clamp function for the state counts.
- Sub-module `dac_seq_regfile`: address decode, clamping, `wr_err` generation, and shadow/live storage (shadow under the macro only).
- Top level: the FSM and the cycle, hold and period counters.

## Test plan
- Reset and map check: after reset, read all outputs and confirm the reset values. Write 0xFF to addr 20 → up_states=10. Write 0 to addr 21 → down_states=1. Write to addr 28 → `wr_err` pulse, no output change.
- Single period: up_states=3, hold_hi=2, down_states=4, hold_lo=0, repeat=1, then `start`.
  - `dac_set`=1 for 5 cycles, then 0 for 4 cycles.
  - `done` at cycle 10 after start.
  - `period_cnt`=1.
- Repeat: repeat=3 with the settings above → 3 identical 9-cycle periods, `done` at cycle 28.
- Abort: assert `abort` in the 2nd cycle of S_FALL → next cycle `dac_en`=0, `busy`=0, no `done`. `start` in the same cycle as `abort` is ignored.
- Start while busy: a second `start` mid-run has no effect; the total run length is unchanged.
- Write during busy:
  - With `DAC_SEQ_SHADOW_EN`: write up_states=7 mid-run → the current run keeps 3; the next run uses 7.
  - Without the macro: the same write pulses `wr_err` and up_states stays 3.
